// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN tile datapath: default operand/accumulator
// widths, the PE stream driver state encoding and a constant-evaluable clog2.
package cnn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUTPUT
    } pe_drv_state_t;

    // Ceiling log2 usable in parameter and port-range expressions. Never
    // returns 0 so the result can always size a vector directly.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pe_stream_driver.sv
// Feeds one MAC processing element from a valid/ready operand stream. Each
// vector is framed by a single PE clear pulse, pairs are forwarded through a
// registered drive stage, and once the PE pipeline has drained the dot product,
// overflow, pair count and truncation flag are offered on a valid/ready port.
module pe_stream_driver
    import cnn_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int MAX_LEN    = 64,
    parameter int PE_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_a,
    input  logic [DATA_W-1:0]           s_b,
    input  logic                        s_last,
    output logic [DATA_W-1:0]           o_pe_a,
    output logic [DATA_W-1:0]           o_pe_b,
    output logic                        o_pe_enable,
    output logic                        o_pe_clear,
    input  logic [ACC_W-1:0]            i_pe_result,
    input  logic                        i_pe_overflow,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [ACC_W-1:0]            m_result,
    output logic                        m_overflow,
    output logic                        m_trunc,
    output logic [clog2(MAX_LEN+1)-1:0] m_count
);

    localparam int CNT_W   = clog2(MAX_LEN + 1);
    localparam int DRAIN_W = clog2(PE_LATENCY + 1);

    localparam logic [CNT_W-1:0]   COUNT_MAX  = CNT_W'(MAX_LEN);
    // The drain lasts PE_LATENCY+1 cycles: the registered drive stage plus the PE.
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LATENCY);

    pe_drv_state_t state_reg;
    pe_drv_state_t state_next;

    logic               stream_ready;
    logic               handshake;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_inc;
    logic               count_full;
    logic [DRAIN_W-1:0] drain_reg;
    logic               drain_done;
    logic               ovf_reg;
    logic               trunc_reg;

    logic [DATA_W-1:0]  pe_a_reg;
    logic [DATA_W-1:0]  pe_b_reg;
    logic               pe_enable_reg;
    logic               pe_clear_reg;

    logic               m_valid_reg;
    logic [ACC_W-1:0]   m_result_reg;
    logic               m_overflow_reg;
    logic               m_trunc_reg;
    logic [CNT_W-1:0]   m_count_reg;

    assign handshake  = s_valid && stream_ready;
    assign count_inc  = count_reg + 1'b1;
    assign count_full = (count_inc == COUNT_MAX);
    assign drain_done = (drain_reg == DRAIN_LAST);

    assign s_ready     = stream_ready;
    assign o_pe_a      = pe_a_reg;
    assign o_pe_b      = pe_b_reg;
    assign o_pe_enable = pe_enable_reg;
    assign o_pe_clear  = pe_clear_reg;
    assign m_valid     = m_valid_reg;
    assign m_result    = m_result_reg;
    assign m_overflow  = m_overflow_reg;
    assign m_trunc     = m_trunc_reg;
    assign m_count     = m_count_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; the stream side is only ready while streaming.
    always_comb begin
        state_next   = state_reg;
        stream_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_valid) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = STREAM;
            end
            STREAM: begin
                stream_ready = 1'b1;
                // A vector ends on its last pair or when it is full.
                if (s_valid && (s_last || count_full)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered PE drive: clear on vector start, one enable per accepted pair.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            pe_a_reg      <= '0;
            pe_b_reg      <= '0;
            pe_enable_reg <= 1'b0;
            pe_clear_reg  <= 1'b0;
        end else begin
            pe_clear_reg  <= (state_reg == IDLE) && s_valid;
            pe_enable_reg <= handshake;
            if (handshake) begin
                pe_a_reg <= s_a;
                pe_b_reg <= s_b;
            end
        end
    end

    // Per-vector bookkeeping and result capture at the end of the drain.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            count_reg      <= '0;
            drain_reg      <= '0;
            ovf_reg        <= 1'b0;
            trunc_reg      <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_result_reg   <= '0;
            m_overflow_reg <= 1'b0;
            m_trunc_reg    <= 1'b0;
            m_count_reg    <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    count_reg <= '0;
                    ovf_reg   <= 1'b0;
                    trunc_reg <= 1'b0;
                end
                STREAM: begin
                    // Also folding the flag in while streaming keeps an
                    // early overflow even if the PE only pulses it.
                    ovf_reg   <= ovf_reg | i_pe_overflow;
                    drain_reg <= '0;
                    if (handshake) begin
                        count_reg <= count_inc;
                        if (count_full && !s_last) begin
                            trunc_reg <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    ovf_reg   <= ovf_reg | i_pe_overflow;
                    drain_reg <= drain_reg + 1'b1;
                    if (drain_done) begin
                        m_valid_reg    <= 1'b1;
                        m_result_reg   <= i_pe_result;
                        m_overflow_reg <= ovf_reg | i_pe_overflow;
                        m_trunc_reg    <= trunc_reg;
                        m_count_reg    <= count_reg;
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver paired with a behavioural stand-in for the
// simple_pe_basic MAC element. Vectors are split into expected results from
// the stream rules (end on last, or after MAX_LEN pairs) using plain arithmetic.
module tb_pe_stream_driver;

    localparam int DATA_W     = 8;
    localparam int ACC_W      = 16;
    localparam int MAX_LEN    = 4;
    localparam int PE_LATENCY = 1;
    localparam int CNT_W      = $clog2(MAX_LEN + 1);
    localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN    = -(1 << (ACC_W - 1));

    logic              clk = 1'b0;
    logic              i_reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_last;
    logic [DATA_W-1:0] o_pe_a;
    logic [DATA_W-1:0] o_pe_b;
    logic              o_pe_enable;
    logic              o_pe_clear;
    logic [ACC_W-1:0]  i_pe_result;
    logic              i_pe_overflow;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_result;
    logic              m_overflow;
    logic              m_trunc;
    logic [CNT_W-1:0]  m_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int clr_seen     = 0;
    int en_seen      = 0;
    int both_seen    = 0;

    logic [DATA_W-1:0] pa[$];
    logic [DATA_W-1:0] pb[$];
    bit                pl[$];
    logic [ACC_W-1:0]  exp_res[$];
    logic [ACC_W-1:0]  obs_res[$];
    bit                exp_ovf[$];
    bit                obs_ovf[$];
    bit                exp_trunc[$];
    bit                obs_trunc[$];
    logic [CNT_W-1:0]  exp_cnt[$];
    logic [CNT_W-1:0]  obs_cnt[$];

    always #5 clk = ~clk;

    pe_stream_driver #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .MAX_LEN    (MAX_LEN),
        .PE_LATENCY (PE_LATENCY)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_a           (s_a),
        .s_b           (s_b),
        .s_last        (s_last),
        .o_pe_a        (o_pe_a),
        .o_pe_b        (o_pe_b),
        .o_pe_enable   (o_pe_enable),
        .o_pe_clear    (o_pe_clear),
        .i_pe_result   (i_pe_result),
        .i_pe_overflow (i_pe_overflow),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_result      (m_result),
        .m_overflow    (m_overflow),
        .m_trunc       (m_trunc),
        .m_count       (m_count)
    );

    // Signed multiply-accumulate with wrap-around, as the PE performs it.
    function automatic logic [ACC_W-1:0] mac_wrap(input logic signed [ACC_W-1:0] acc,
                                                  input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
        int s;
        s = int'(acc) + int'(a) * int'(b);
        return s[ACC_W-1:0];
    endfunction

    function automatic bit add_ovf(input logic signed [ACC_W-1:0] acc,
                                   input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
        int s;
        s = int'(acc) + int'(a) * int'(b);
        return (s > ACC_MAX) || (s < ACC_MIN);
    endfunction

    // PE stand-in: one-cycle latency accumulator with a sticky overflow flag.
    always_ff @(posedge clk) begin
        if (i_reset || o_pe_clear) begin
            i_pe_result   <= '0;
            i_pe_overflow <= 1'b0;
        end else if (o_pe_enable) begin
            i_pe_result   <= mac_wrap(i_pe_result, o_pe_a, o_pe_b);
            i_pe_overflow <= i_pe_overflow | add_ovf(i_pe_result, o_pe_a, o_pe_b);
        end
    end

    // Count PE control pulses so scenarios can check clears and enables.
    always @(negedge clk) begin
        if (o_pe_clear) clr_seen <= clr_seen + 1;
        if (o_pe_enable) en_seen <= en_seen + 1;
        if (o_pe_clear && o_pe_enable) both_seen <= both_seen + 1;
    end

    task automatic new_stream();
        pa.delete();
        pb.delete();
        pl.delete();
    endtask

    task automatic add_pair(input int a, input int b, input bit last);
        pa.push_back(a[DATA_W-1:0]);
        pb.push_back(b[DATA_W-1:0]);
        pl.push_back(last);
    endtask

    // Reference: cut the pair stream into vectors and accumulate each one.
    task automatic build_expect();
        logic [ACC_W-1:0] acc;
        bit ovf;
        int cnt;
        exp_res.delete();
        exp_ovf.delete();
        exp_trunc.delete();
        exp_cnt.delete();
        acc = '0;
        ovf = 1'b0;
        cnt = 0;
        for (int i = 0; i < pa.size(); i++) begin
            ovf = ovf | add_ovf(acc, pa[i], pb[i]);
            acc = mac_wrap(acc, pa[i], pb[i]);
            cnt++;
            if (pl[i] || cnt == MAX_LEN) begin
                exp_res.push_back(acc);
                exp_ovf.push_back(ovf);
                exp_cnt.push_back(CNT_W'(cnt));
                exp_trunc.push_back(!pl[i]);
                acc = '0;
                ovf = 1'b0;
                cnt = 0;
            end
        end
    endtask

    task automatic produce(input int gap_pct, input bit alternate);
        int wait_cnt;
        for (int i = 0; i < pa.size(); i++) begin
            if (alternate && i > 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            while (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_a     = pa[i];
            s_b     = pb[i];
            s_last  = pl[i];
            wait_cnt = 0;
            while (!s_ready && wait_cnt < 300) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!s_ready) begin
                tests_run++;
                tests_failed++;
                $display("FAIL pair_accept_timeout pair=%0d: s_ready=%0b after %0d cycles, required 1", i, s_ready, wait_cnt);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic consume(input int n, input int bp_pct, input int hold);
        int wait_cnt;
        logic [ACC_W-1:0] snap_res;
        logic snap_ovf, snap_trunc;
        logic [CNT_W-1:0] snap_cnt;
        for (int k = 0; k < n; k++) begin
            m_ready  = 1'b0;
            wait_cnt = 0;
            while (!m_valid && wait_cnt < 300) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!m_valid) begin
                tests_run++;
                tests_failed++;
                $display("FAIL result_timeout result=%0d: m_valid=%0b after %0d cycles, required 1", k, m_valid, wait_cnt);
                return;
            end
            if (hold > 0) begin
                snap_res   = m_result;
                snap_ovf   = m_overflow;
                snap_trunc = m_trunc;
                snap_cnt   = m_count;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    tests_run++;
                    if (m_valid !== 1'b1 || m_result !== snap_res || m_overflow !== snap_ovf ||
                        m_trunc !== snap_trunc || m_count !== snap_cnt || s_ready !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL hold_stable cycle=%0d: m_valid=%0b m_result=%0d m_count=%0d s_ready=%0b, required m_valid=1 m_result=%0d m_count=%0d s_ready=0",
                                 h, m_valid, m_result, m_count, s_ready, snap_res, snap_cnt);
                    end
                end
            end else begin
                while (int'($urandom_range(99)) < bp_pct) @(negedge clk);
            end
            m_ready = 1'b1;
            obs_res.push_back(m_result);
            obs_ovf.push_back(m_overflow);
            obs_trunc.push_back(m_trunc);
            obs_cnt.push_back(m_count);
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    task automatic run_stream(input int gap_pct, input bit alternate, input int bp_pct, input int hold);
        obs_res.delete();
        obs_ovf.delete();
        obs_trunc.delete();
        obs_cnt.delete();
        build_expect();
        fork
            produce(gap_pct, alternate);
            consume(exp_res.size(), bp_pct, hold);
        join
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({s_ready, o_pe_enable, o_pe_clear, m_valid, m_overflow, m_trunc} !== 6'b0 ||
            o_pe_a !== '0 || o_pe_b !== '0 || m_result !== '0 || m_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: s_ready=%0b en=%0b clr=%0b m_valid=%0b m_result=%0d m_count=%0d, required all 0",
                     s_ready, o_pe_enable, o_pe_clear, m_valid, m_result, m_count);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int clr0, en0;
        new_stream();
        add_pair(3, 4, 1'b0);
        add_pair(5, 6, 1'b1);
        clr0 = clr_seen;
        en0  = en_seen;
        run_stream(0, 1'b0, 0, 0);
        tests_run++;
        if (obs_res.size() != 1) begin
            tests_failed++;
            $display("FAIL basic_results: got %0d results, required 1", obs_res.size());
        end else begin
            tests_run++;
            if (obs_res[0] !== ACC_W'(42) || obs_cnt[0] !== CNT_W'(2) || obs_ovf[0] !== 1'b0 || obs_trunc[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_value: result=%0d count=%0d ovf=%0b trunc=%0b, required 42 2 0 0",
                         obs_res[0], obs_cnt[0], obs_ovf[0], obs_trunc[0]);
            end
        end
        tests_run++;
        if (clr_seen - clr0 != 1 || en_seen - en0 != 2) begin
            tests_failed++;
            $display("FAIL basic_pulses: clears=%0d enables=%0d, required 1 2", clr_seen - clr0, en_seen - en0);
        end
    endtask

    task automatic test_overflow();
        new_stream();
        add_pair(-128, -128, 1'b0);
        add_pair(-128, -128, 1'b0);
        add_pair(-128, -128, 1'b1);
        run_stream(0, 1'b0, 0, 0);
        tests_run++;
        if (obs_res.size() != 1) begin
            tests_failed++;
            $display("FAIL overflow_results: got %0d results, required 1", obs_res.size());
        end else begin
            tests_run++;
            if (obs_ovf[0] !== 1'b1 || obs_cnt[0] !== CNT_W'(3) || obs_res[0] !== 16'hC000 || obs_trunc[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL overflow_value: ovf=%0b count=%0d result=%h trunc=%0b, required 1 3 c000 0",
                         obs_ovf[0], obs_cnt[0], obs_res[0], obs_trunc[0]);
            end
        end
    endtask

    task automatic test_bubbles();
        int en0;
        new_stream();
        for (int i = 0; i < 4; i++) add_pair(2, 2, i == 3);
        en0 = en_seen;
        run_stream(0, 1'b1, 0, 0);
        tests_run++;
        if (obs_res.size() != 1 || obs_res[0] !== ACC_W'(16) || obs_cnt[0] !== CNT_W'(4) || obs_trunc[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubbles_value: results=%0d first=%0d count=%0d trunc=%0b, required 1 16 4 0",
                     obs_res.size(), (obs_res.size() > 0) ? obs_res[0] : '0,
                     (obs_cnt.size() > 0) ? obs_cnt[0] : '0, (obs_trunc.size() > 0) ? obs_trunc[0] : 1'b0);
        end
        tests_run++;
        if (en_seen - en0 != 4) begin
            tests_failed++;
            $display("FAIL bubbles_enables: enables=%0d, required 4", en_seen - en0);
        end
    endtask

    task automatic test_truncation();
        int clr0;
        new_stream();
        for (int i = 0; i < 6; i++) add_pair(1, 1, i == 5);
        clr0 = clr_seen;
        run_stream(0, 1'b0, 0, 0);
        tests_run++;
        if (obs_res.size() != 2) begin
            tests_failed++;
            $display("FAIL trunc_results: got %0d results, required 2", obs_res.size());
        end else begin
            tests_run++;
            if (obs_res[0] !== ACC_W'(4) || obs_trunc[0] !== 1'b1 || obs_cnt[0] !== CNT_W'(4)) begin
                tests_failed++;
                $display("FAIL trunc_first: result=%0d trunc=%0b count=%0d, required 4 1 4", obs_res[0], obs_trunc[0], obs_cnt[0]);
            end
            tests_run++;
            if (obs_res[1] !== ACC_W'(2) || obs_trunc[1] !== 1'b0 || obs_cnt[1] !== CNT_W'(2)) begin
                tests_failed++;
                $display("FAIL trunc_second: result=%0d trunc=%0b count=%0d, required 2 0 2", obs_res[1], obs_trunc[1], obs_cnt[1]);
            end
        end
        tests_run++;
        if (clr_seen - clr0 != 2) begin
            tests_failed++;
            $display("FAIL trunc_clears: clears=%0d, required 2", clr_seen - clr0);
        end
    endtask

    task automatic test_backpressure();
        for (int pass = 0; pass < 2; pass++) begin
            new_stream();
            for (int i = 0; i < 3; i++) add_pair(int'($urandom_range(255)), int'($urandom_range(255)), i == 2);
            run_stream(pass * 20, 1'b0, pass * 30, (pass == 0) ? 10 : 0);
            tests_run++;
            if (obs_res.size() != exp_res.size()) begin
                tests_failed++;
                $display("FAIL backpressure_results pass=%0d: got %0d results, required %0d", pass, obs_res.size(), exp_res.size());
            end else begin
                foreach (exp_res[i]) begin
                    tests_run++;
                    if (obs_res[i] !== exp_res[i] || obs_ovf[i] !== exp_ovf[i] || obs_cnt[i] !== exp_cnt[i] || obs_trunc[i] !== exp_trunc[i]) begin
                        tests_failed++;
                        $display("FAIL backpressure_value pass=%0d: result=%0d ovf=%0b count=%0d trunc=%0b, required %0d %0b %0d %0b",
                                 pass, obs_res[i], obs_ovf[i], obs_cnt[i], obs_trunc[i], exp_res[i], exp_ovf[i], exp_cnt[i], exp_trunc[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int len, a, b;
        for (int it = 0; it < 25; it++) begin
            new_stream();
            len = int'($urandom_range(1, 9));
            for (int j = 0; j < len; j++) begin
                a = ($urandom_range(3) == 0) ? -128 : int'($urandom_range(255));
                b = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? -128 : 127) : int'($urandom_range(255));
                add_pair(a, b, (j == len - 1) || ($urandom_range(9) == 0));
            end
            run_stream(30, 1'b0, 30, 0);
            tests_run++;
            if (obs_res.size() != exp_res.size()) begin
                tests_failed++;
                $display("FAIL random_results iter=%0d: got %0d results, required %0d", it, obs_res.size(), exp_res.size());
            end else begin
                foreach (exp_res[i]) begin
                    tests_run++;
                    if (obs_res[i] !== exp_res[i] || obs_ovf[i] !== exp_ovf[i] || obs_cnt[i] !== exp_cnt[i] || obs_trunc[i] !== exp_trunc[i]) begin
                        tests_failed++;
                        $display("FAIL random_value iter=%0d idx=%0d: result=%0d ovf=%0b count=%0d trunc=%0b, required %0d %0b %0d %0b",
                                 it, i, obs_res[i], obs_ovf[i], obs_cnt[i], obs_trunc[i], exp_res[i], exp_ovf[i], exp_cnt[i], exp_trunc[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int quiet_bad;
        new_stream();
        add_pair(9, 9, 1'b0);
        add_pair(9, 9, 1'b0);
        produce(0, 1'b0);
        i_reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({s_ready, o_pe_enable, o_pe_clear, m_valid, m_overflow, m_trunc} !== 6'b0 ||
            o_pe_a !== '0 || o_pe_b !== '0 || m_result !== '0 || m_count !== '0) begin
            tests_failed++;
            $display("FAIL midstream_reset_outputs: s_ready=%0b en=%0b a=%0d m_valid=%0b m_result=%0d m_count=%0d, required all 0",
                     s_ready, o_pe_enable, o_pe_a, m_valid, m_result, m_count);
        end
        i_reset = 1'b0;
        quiet_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid !== 1'b0) quiet_bad++;
        end
        tests_run++;
        if (quiet_bad != 0) begin
            tests_failed++;
            $display("FAIL midstream_no_result: m_valid high on %0d cycles, required 0", quiet_bad);
        end
        new_stream();
        add_pair(7, 7, 1'b1);
        run_stream(0, 1'b0, 0, 0);
        tests_run++;
        if (obs_res.size() != 1 || obs_res[0] !== ACC_W'(49) || obs_cnt[0] !== CNT_W'(1)) begin
            tests_failed++;
            $display("FAIL midstream_next_vector: results=%0d first=%0d count=%0d, required 1 49 1",
                     obs_res.size(), (obs_res.size() > 0) ? obs_res[0] : '0, (obs_cnt.size() > 0) ? obs_cnt[0] : '0);
        end
    endtask

    task automatic test_exclusive_controls();
        tests_run++;
        if (both_seen != 0) begin
            tests_failed++;
            $display("FAIL clear_enable_exclusive: overlapping cycles=%0d, required 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_bubbles();
        test_truncation();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_exclusive_controls();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
